// File: rtl/rb_if.sv
// Valid/ready streaming bundle used on both sides of ring_buffer.
// The sink modport is the consumer view; the source modport is the producer view.
interface rb_if #(
  parameter type data_t = logic [31:0]
);
  logic  valid;
  logic  ready;
  data_t data;

  modport sink   (input valid, input data, output ready);
  modport source (output valid, output data, input ready);
endinterface

// File: rtl/ring_buffer.sv
// Single-clock first-word-fall-through FIFO ring buffer with valid/ready on both sides.
// Define RING_BUFFER_OVERWRITE_EN to accept writes when full, dropping the oldest entry.
module ring_buffer #(
  parameter type data_t = logic [31:0],
  parameter int  DEPTH  = 16,
  parameter int  AW     = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic full,
  output logic empty,
  rb_if.sink   i_bus,
  rb_if.source o_bus
);

  generate
    if (AW < 1 || DEPTH != (1 << AW)) begin : g_bad_cfg
      $error("ring_buffer: DEPTH must equal 2**AW with AW >= 1");
    end
  endgenerate

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  data_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic ready_int;
  logic valid_int;
  logic push;
  logic pop;
  logic drop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign valid_int = !empty;

`ifdef RING_BUFFER_OVERWRITE_EN
  assign ready_int = rst_n;
  assign push      = i_bus.valid & ready_int;
  assign pop       = valid_int & o_bus.ready;
  // A write into a full buffer with no read evicts the oldest word.
  assign drop      = push & full & !pop;
`else
  assign ready_int = rst_n & !full;
  assign push      = i_bus.valid & ready_int;
  assign pop       = valid_int & o_bus.ready;
  assign drop      = 1'b0;
`endif

  assign i_bus.ready = ready_int;
  assign o_bus.valid = valid_int;
  assign o_bus.data  = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop || drop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop && !drop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_bus.data;
    end
  end

endmodule

// File: tb/tb_ring_buffer.sv
// Directed self-checking bench for ring_buffer; covers RING_BUFFER_OVERWRITE_EN when defined.
module tb_ring_buffer;

  logic clk;
  logic rst_n;
  logic full;
  logic empty;

  rb_if #(.data_t(logic [31:0])) i_bus ();
  rb_if #(.data_t(logic [31:0])) o_bus ();

  ring_buffer #(
    .data_t(logic [31:0]),
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .full (full),
    .empty(empty),
    .i_bus(i_bus),
    .o_bus(o_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_idx;
    int rd_idx;
    int cyc;
    logic do_push;
    logic do_pop;

    rst_n       = 1'b0;
    i_bus.valid = 1'b0;
    i_bus.data  = '0;
    o_bus.ready = 1'b0;

    // Reset held for 5 cycles
    repeat (5) step();
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovalid", o_bus.valid, 1'b0);
    check("rst_iready", i_bus.ready, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_iready", i_bus.ready, 1'b1);

    // Single word with consumer ready
    o_bus.ready = 1'b1;
    i_bus.valid = 1'b1;
    i_bus.data  = 32'hDEADBEEF;
    step();
    i_bus.valid = 1'b0;
    #1;
    check("single_valid", o_bus.valid, 1'b1);
    check("single_data", o_bus.data, 32'hDEADBEEF);
    check("single_not_empty", empty, 1'b0);
    step();
    check("single_empty_after", empty, 1'b1);
    check("single_valid_after", o_bus.valid, 1'b0);

`ifdef RING_BUFFER_OVERWRITE_EN
    // Overfill: oldest four words are dropped
    o_bus.ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      i_bus.valid = 1'b1;
      i_bus.data  = i;
      #1;
      check("ovw_iready", i_bus.ready, 1'b1);
      step();
    end
    i_bus.valid = 1'b0;
    #1;
    check("ovw_full", full, 1'b1);
    o_bus.ready = 1'b1;
    for (int i = 4; i < 20; i++) begin
      #1;
      check("ovw_drain_valid", o_bus.valid, 1'b1);
      check("ovw_drain_data", o_bus.data, i);
      step();
    end
    check("ovw_drain_empty", empty, 1'b1);
    o_bus.ready = 1'b0;
`else
    // Fill to 16, reject a 17th, then drain in order
    o_bus.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_bus.valid = 1'b1;
      i_bus.data  = i;
      #1;
      check("fill_iready", i_bus.ready, 1'b1);
      step();
    end
    i_bus.data = 32'd16;
    #1;
    check("fill_full", full, 1'b1);
    check("fill_iready_low", i_bus.ready, 1'b0);
    step();
    i_bus.valid = 1'b0;
    check("fill_still_full", full, 1'b1);
    o_bus.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("drain_valid", o_bus.valid, 1'b1);
      check("drain_data", o_bus.data, i);
      step();
    end
    check("drain_empty", empty, 1'b1);
    check("drain_not_full", full, 1'b0);
    o_bus.ready = 1'b0;
`endif

    // Wrap-around with random handshakes
    wr_idx = 0;
    rd_idx = 0;
    cyc    = 0;
    while (rd_idx < 40 && cyc < 2000) begin
`ifdef RING_BUFFER_OVERWRITE_EN
      i_bus.valid = (wr_idx < 40) && ($urandom_range(0, 1) == 1) && !full;
`else
      i_bus.valid = (wr_idx < 40) && ($urandom_range(0, 1) == 1);
`endif
      i_bus.data  = 32'(100 + wr_idx);
      o_bus.ready = ($urandom_range(0, 2) != 0);
      #1;
      do_push = i_bus.valid & i_bus.ready;
      do_pop  = o_bus.valid & o_bus.ready;
      if (do_pop) begin
        check("wrap_data", o_bus.data, 32'(100 + rd_idx));
        rd_idx++;
      end
      if (do_push) wr_idx++;
      step();
      cyc++;
    end
    i_bus.valid = 1'b0;
    o_bus.ready = 1'b0;
    check("wrap_all_read", rd_idx, 40);
    #1;
    check("wrap_empty", empty, 1'b1);

    // Preload 8 words, then 20 cycles of concurrent push and pop
    for (int i = 0; i < 8; i++) begin
      i_bus.valid = 1'b1;
      i_bus.data  = 200 + i;
      step();
    end
    o_bus.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_bus.data = 208 + k;
      #1;
      check("conc_data", o_bus.data, 200 + k);
      check("conc_full", full, 1'b0);
      check("conc_empty", empty, 1'b0);
      step();
    end
    i_bus.valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("conc_tail_data", o_bus.data, 220 + k);
      step();
    end
    check("conc_tail_empty", empty, 1'b1);
    o_bus.ready = 1'b0;

    // Reset asserted mid-stream between clock edges
    for (int i = 0; i < 3; i++) begin
      i_bus.valid = 1'b1;
      i_bus.data  = 300 + i;
      step();
    end
    i_bus.valid = 1'b0;
    #1;
    check("mid_not_empty", empty, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_ovalid", o_bus.valid, 1'b0);
    check("mid_rst_iready", i_bus.ready, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    check("mid_post_empty", empty, 1'b1);
    i_bus.valid = 1'b1;
    i_bus.data  = 32'hCAFE0001;
    step();
    i_bus.valid = 1'b0;
    #1;
    check("mid_fresh_data", o_bus.data, 32'hCAFE0001);
    o_bus.ready = 1'b1;
    step();
    check("mid_final_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
